// File: rtl/prim_shadow_reg_bank_if.sv
// prim_shadow_reg_bank_if: software/hardware access and status bundle for the shadow register bank
interface prim_shadow_reg_bank_if #(
    parameter int DW      = 32,
    parameter int NumRegs = 4
);
    localparam int AW = $clog2(NumRegs);
    logic                    re_i;
    logic                    we_i;
    logic [AW-1:0]           addr_i;
    logic [DW-1:0]           wd_i;
    logic [NumRegs-1:0]      de_i;
    logic [NumRegs*DW-1:0]   d_i;
    logic [NumRegs*DW-1:0]   q_o;
    logic [NumRegs-1:0]      qe_o;
    logic [NumRegs-1:0]      phase_o;
    logic [NumRegs-1:0]      err_update_o;
    logic [NumRegs-1:0]      err_storage_o;
    logic                    err_timeout_o;
    logic [7:0]              err_cnt_o;
    modport master (
        output re_i, we_i, addr_i, wd_i, de_i, d_i,
        input  q_o, qe_o, phase_o, err_update_o, err_storage_o, err_timeout_o, err_cnt_o
    );
    modport slave (
        input  re_i, we_i, addr_i, wd_i, de_i, d_i,
        output q_o, qe_o, phase_o, err_update_o, err_storage_o, err_timeout_o, err_cnt_o
    );
endinterface

// File: rtl/prim_shadow_reg_bank.sv
// prim_shadow_reg_bank: bank of double-write shadowed registers; PRIM_SHADOW_BANK_SCRUB_EN selects one-register-per-cycle storage scrubbing
module prim_shadow_reg_bank #(
    parameter int              DW            = 32,
    parameter int              NumRegs       = 4,
    parameter logic [DW-1:0]   RESVAL        = '0,
    parameter int              TimeoutCycles = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    prim_shadow_reg_bank_if.slave bus
);
    localparam int AW = $clog2(NumRegs);
    localparam int TW = $clog2(TimeoutCycles + 2);

    logic [NumRegs-1:0][DW-1:0] staged_q, shadow_q, comm_q, staged_d, shadow_d, comm_d;
    logic [NumRegs-1:0]         qe_q, qe_d, eu_q, eu_d, st_q, st_d;
    logic                       pend_q, pend_d, et_q, et_d, touched, a_ok;
    logic [AW-1:0]              pidx_q, pidx_d;
    logic [TW-1:0]              tmr_q, tmr_d;
    logic [7:0]                 cnt_q, cnt_d;

`ifdef PRIM_SHADOW_BANK_SCRUB_EN
    logic [AW-1:0] ptr_q;
    // single comparator walks the bank, latching a sticky error for the scrubbed register
    always_comb begin
        st_d = st_q;
        if (~shadow_q[ptr_q] != comm_q[ptr_q]) st_d[ptr_q] = 1'b1;
    end
    // scrub pointer advances one register per cycle and wraps
    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= (int'(ptr_q) == NumRegs - 1) ? '0 : ptr_q + 1'b1;
    end
`else
    // every register's shadow is compared against its committed value each cycle
    always_comb begin
        for (int i = 0; i < NumRegs; i++) st_d[i] = st_q[i] | (~shadow_q[i] != comm_q[i]);
    end
`endif

    // hardware writes, software double-write protocol, read abort and timeout
    always_comb begin
        staged_d = staged_q;
        shadow_d = shadow_q;
        comm_d   = comm_q;
        pend_d   = pend_q;
        pidx_d   = pidx_q;
        tmr_d    = tmr_q;
        qe_d     = '0;
        eu_d     = '0;
        et_d     = 1'b0;
        touched  = 1'b0;
        a_ok     = int'(bus.addr_i) < NumRegs;
        for (int i = 0; i < NumRegs; i++) begin
            if (bus.de_i[i] && !st_q[i]) begin
                comm_d[i]   = bus.d_i[i*DW +: DW];
                shadow_d[i] = ~bus.d_i[i*DW +: DW];
                qe_d[i]     = 1'b1;
                if (pend_q && int'(pidx_q) == i) begin
                    pend_d  = 1'b0;
                    touched = 1'b1;
                end
            end
        end
        if (bus.we_i && a_ok && !st_q[bus.addr_i] && !bus.de_i[bus.addr_i]) begin
            touched = 1'b1;
            if (pend_d && pidx_q == bus.addr_i) begin
                pend_d = 1'b0;
                if (bus.wd_i == ~staged_q[bus.addr_i]) begin
                    comm_d[bus.addr_i]   = bus.wd_i;
                    shadow_d[bus.addr_i] = staged_q[bus.addr_i];
                    qe_d[bus.addr_i]     = 1'b1;
                end else begin
                    eu_d[bus.addr_i] = 1'b1;
                end
            end else begin
                if (pend_d) eu_d[pidx_q] = 1'b1;
                staged_d[bus.addr_i] = ~bus.wd_i;
                pend_d = 1'b1;
                pidx_d = bus.addr_i;
                tmr_d  = '0;
            end
        end else if (bus.re_i && a_ok && pend_d && pidx_q == bus.addr_i) begin
            pend_d  = 1'b0;
            touched = 1'b1;
        end
        if (TimeoutCycles != 0 && pend_q && !touched) begin
            if (tmr_q == TW'(TimeoutCycles - 1)) begin
                pend_d = 1'b0;
                et_d   = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
        if (pend_d && st_d[pidx_d]) pend_d = 1'b0;
        cnt_d = (cnt_q != 8'hff && (|eu_d || et_d)) ? cnt_q + 8'd1 : cnt_q;
    end

    // state and registered status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            staged_q <= {NumRegs{~RESVAL}};
            shadow_q <= {NumRegs{~RESVAL}};
            comm_q   <= {NumRegs{RESVAL}};
            pend_q   <= 1'b0;
            pidx_q   <= '0;
            tmr_q    <= '0;
            qe_q     <= '0;
            eu_q     <= '0;
            et_q     <= 1'b0;
            st_q     <= '0;
            cnt_q    <= '0;
        end else begin
            staged_q <= staged_d;
            shadow_q <= shadow_d;
            comm_q   <= comm_d;
            pend_q   <= pend_d;
            pidx_q   <= pidx_d;
            tmr_q    <= tmr_d;
            qe_q     <= qe_d;
            eu_q     <= eu_d;
            et_q     <= et_d;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.q_o           = comm_q;
    assign bus.qe_o          = qe_q;
    assign bus.phase_o       = pend_q ? (NumRegs'(1) << pidx_q) : '0;
    assign bus.err_update_o  = eu_q;
    assign bus.err_storage_o = st_q;
    assign bus.err_timeout_o = et_q;
    assign bus.err_cnt_o     = cnt_q;
endmodule

// File: tb/tb_prim_shadow_reg_bank.sv
// tb_prim_shadow_reg_bank: vector table through a scoreboard queue plus timeout, saturation, storage and reset sequences
module tb_prim_shadow_reg_bank;
    typedef struct {
        logic         re, we;
        logic [1:0]   addr;
        logic [31:0]  wd;
        logic [3:0]   de;
        logic [31:0]  d;
        logic [127:0] q;
        logic [3:0]   qe, ph, eu;
        logic         et;
        logic [7:0]   cnt;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vt[15];
    vec_t exp_q[$];
    vec_t e;
    logic [3:0][31:0] corrupt;
    logic [127:0] q1, q5, q9, q14, q15;
    bit   seen;
`ifdef PRIM_SHADOW_BANK_SCRUB_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 1;
`endif

    prim_shadow_reg_bank_if #(.DW(32), .NumRegs(4)) bus();

    prim_shadow_reg_bank #(.DW(32), .NumRegs(4), .RESVAL(32'h0), .TimeoutCycles(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [1:0] addr, input logic [31:0] wd,
                         input logic [3:0] de, input logic [31:0] d);
        bus.re_i = re; bus.we_i = we; bus.addr_i = addr; bus.wd_i = wd; bus.de_i = de; bus.d_i = {4{d}};
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input logic re, input logic we, input logic [1:0] addr, input logic [31:0] wd,
                                input logic [3:0] de, input logic [31:0] d, input logic [127:0] q,
                                input logic [3:0] qe, input logic [3:0] ph, input logic [3:0] eu,
                                input logic et, input logic [7:0] cnt);
        vec_t v;
        v.re = re; v.we = we; v.addr = addr; v.wd = wd; v.de = de; v.d = d;
        v.q = q; v.qe = qe; v.ph = ph; v.eu = eu; v.et = et; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        q1  = {32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
        q5  = q1;
        q9  = {32'h33333333, 32'h0, 32'hA5A5A5A5, 32'h0};
        q14 = {32'h33333333, 32'h0, 32'h66666666, 32'h0};
        q15 = {32'h33333333, 32'h0, 32'h66666666, 32'h77777777};
        vt[0]  = mk(0, 1, 1, 32'hA5A5A5A5, 4'h0, 0,            128'h0, 4'h0, 4'b0010, 4'h0, 0, 0);
        vt[1]  = mk(0, 1, 1, 32'hA5A5A5A5, 4'h0, 0,            q1,     4'b0010, 4'h0, 4'h0, 0, 0);
        vt[2]  = mk(0, 0, 0, 32'h0,        4'h0, 0,            q1,     4'h0, 4'h0, 4'h0, 0, 0);
        vt[3]  = mk(0, 1, 0, 32'h1,        4'h0, 0,            q1,     4'h0, 4'b0001, 4'h0, 0, 0);
        vt[4]  = mk(0, 1, 0, 32'h2,        4'h0, 0,            q5,     4'h0, 4'h0, 4'b0001, 0, 1);
        vt[5]  = mk(0, 0, 0, 32'h0,        4'h0, 0,            q5,     4'h0, 4'h0, 4'h0, 0, 1);
        vt[6]  = mk(0, 1, 0, 32'h11111111, 4'h0, 0,            q5,     4'h0, 4'b0001, 4'h0, 0, 1);
        vt[7]  = mk(0, 1, 3, 32'h22222222, 4'h0, 0,            q5,     4'h0, 4'b1000, 4'b0001, 0, 2);
        vt[8]  = mk(0, 0, 0, 32'h0,        4'b1000, 32'h33333333, q9,  4'b1000, 4'h0, 4'h0, 0, 2);
        vt[9]  = mk(0, 1, 2, 32'h44444444, 4'h0, 0,            q9,     4'h0, 4'b0100, 4'h0, 0, 2);
        vt[10] = mk(1, 0, 2, 32'h0,        4'h0, 0,            q9,     4'h0, 4'h0, 4'h0, 0, 2);
        vt[11] = mk(1, 0, 2, 32'h0,        4'h0, 0,            q9,     4'h0, 4'h0, 4'h0, 0, 2);
        vt[12] = mk(0, 1, 1, 32'h5,        4'h0, 0,            q9,     4'h0, 4'b0010, 4'h0, 0, 2);
        vt[13] = mk(0, 1, 1, 32'h5,        4'b0010, 32'h66666666, q14, 4'b0010, 4'h0, 4'h0, 0, 2);
        vt[14] = mk(0, 0, 0, 32'h0,        4'b0001, 32'h77777777, q15, 4'b0001, 4'h0, 4'h0, 0, 2);

        idle();
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_q", bus.q_o, 128'h0);
        chk("rst_phase", 128'(bus.phase_o), 128'h0);
        chk("rst_qe", 128'(bus.qe_o), 128'h0);
        chk("rst_err", 128'({bus.err_update_o, bus.err_storage_o, bus.err_timeout_o}), 128'h0);
        chk("rst_cnt", 128'(bus.err_cnt_o), 128'h0);

        for (int k = 0; k < 15; k++) begin
            drive(vt[k].re, vt[k].we, vt[k].addr, vt[k].wd, vt[k].de, vt[k].d);
            exp_q.push_back(vt[k]);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("v%0d_q", k), bus.q_o, e.q);
            chk($sformatf("v%0d_qe", k), 128'(bus.qe_o), 128'(e.qe));
            chk($sformatf("v%0d_phase", k), 128'(bus.phase_o), 128'(e.ph));
            chk($sformatf("v%0d_eu", k), 128'(bus.err_update_o), 128'(e.eu));
            chk($sformatf("v%0d_et", k), 128'(bus.err_timeout_o), 128'(e.et));
            chk($sformatf("v%0d_cnt", k), 128'(bus.err_cnt_o), 128'(e.cnt));
        end

        drive(0, 1, 2, 32'h88888888, 4'h0, 0);
        tick();
        idle();
        for (int k = 0; k < 15; k++) begin
            tick();
            chk($sformatf("to_wait%0d_phase", k), 128'(bus.phase_o), 128'(4'b0100));
            chk($sformatf("to_wait%0d_et", k), 128'(bus.err_timeout_o), 128'h0);
        end
        tick();
        chk("to_et", 128'(bus.err_timeout_o), 128'h1);
        chk("to_phase", 128'(bus.phase_o), 128'h0);
        chk("to_cnt", 128'(bus.err_cnt_o), 128'd3);
        tick();
        chk("to_et_clr", 128'(bus.err_timeout_o), 128'h0);
        drive(0, 1, 2, 32'h88888888, 4'h0, 0);
        tick();
        chk("to_restart_phase", 128'(bus.phase_o), 128'(4'b0100));
        tick();
        chk("to_commit_q2", 128'(bus.q_o[64 +: 32]), 128'h88888888);
        chk("to_commit_qe", 128'(bus.qe_o), 128'(4'b0100));

        for (int k = 0; k < 300; k++) begin
            drive(0, 1, 0, 32'h1, 4'h0, 0);
            tick();
            drive(0, 1, 0, 32'h2, 4'h0, 0);
            tick();
        end
        chk("sat_eu", 128'(bus.err_update_o), 128'(4'b0001));
        chk("sat_cnt", 128'(bus.err_cnt_o), 128'd255);
        chk("sat_q0", 128'(bus.q_o[31:0]), 128'h77777777);
        idle();
        tick();
        chk("sat_hold", 128'(bus.err_cnt_o), 128'd255);

        corrupt = dut.shadow_q;
        corrupt[1][0] = ~corrupt[1][0];
        force dut.shadow_q = corrupt;
        seen = 1'b0;
        for (int k = 0; k < Lat && !seen; k++) begin
            tick();
            seen = bus.err_storage_o[1];
        end
        chk("st_set", 128'(bus.err_storage_o), 128'(4'b0010));
        drive(0, 1, 1, 32'hDEADBEEF, 4'h0, 0);
        tick();
        chk("st_sw_phase", 128'(bus.phase_o), 128'h0);
        tick();
        chk("st_sw_q1", 128'(bus.q_o[32 +: 32]), 128'h66666666);
        chk("st_sw_qe", 128'(bus.qe_o), 128'h0);
        drive(0, 0, 0, 32'h0, 4'b0010, 32'h12345678);
        tick();
        chk("st_hw_q1", 128'(bus.q_o[32 +: 32]), 128'h66666666);
        chk("st_hw_qe", 128'(bus.qe_o), 128'h0);
        idle();
        tick();
        chk("st_sticky", 128'(bus.err_storage_o), 128'(4'b0010));
        chk("st_nocnt", 128'(bus.err_cnt_o), 128'd255);
        rst_i = 1'b1;
        release dut.shadow_q;
        tick();
        rst_i = 1'b0;
        chk("st_rst_err", 128'(bus.err_storage_o), 128'h0);
        chk("st_rst_q", bus.q_o, 128'h0);
        chk("st_rst_cnt", 128'(bus.err_cnt_o), 128'h0);
        tick();
        chk("st_rst_stay", 128'(bus.err_storage_o), 128'h0);

        drive(0, 1, 3, 32'hCAFEF00D, 4'h0, 0);
        tick();
        chk("mid_phase", 128'(bus.phase_o), 128'(4'b1000));
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_phase", 128'(bus.phase_o), 128'h0);
        chk("mid_rst_eu", 128'(bus.err_update_o), 128'h0);
        tick();
        chk("mid_rst_eu2", 128'(bus.err_update_o), 128'h0);
        chk("mid_rst_cnt", 128'(bus.err_cnt_o), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prim_shadow_reg_bank.md
PRIM_SHADOW_REG_BANK -- requirements
Module: prim_shadow_reg_bank

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width of each register.
REQ-002 The block SHALL have parameter NumRegs, default 4, meaning number of shadowed registers (>=2).
REQ-003 The block SHALL have parameter RESVAL, default 0, DW bits, meaning reset value of every committed register.
REQ-004 The block SHALL have parameter TimeoutCycles, default 16, meaning the second-write timeout in cycles, where 0 disables the timeout.
REQ-005 The block SHALL have clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have rst_i, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have re_i, input, 1, a software read strobe qualified by addr_i.
REQ-008 The block SHALL have we_i, input, 1, a software write strobe qualified by addr_i.
REQ-009 The block SHALL have addr_i, input, clog2(NumRegs), the software register index.
REQ-010 The block SHALL have wd_i, input, DW, the software write data.
REQ-011 The block SHALL have de_i, input, NumRegs, per-register hardware write enables.
REQ-012 The block SHALL have d_i, input, NumRegs*DW, hardware write data, where register i occupies bits [i*DW +: DW].
REQ-013 The block SHALL have q_o, output, NumRegs*DW, the committed values.
REQ-014 The block SHALL have qe_o, output, NumRegs, a one-cycle commit pulse per register.
REQ-015 The block SHALL have phase_o, output, NumRegs, the per-register phase (1 = first write staged).
REQ-016 The block SHALL have err_update_o, output, NumRegs, a one-cycle mismatch or abort pulse per register.
REQ-017 The block SHALL have err_storage_o, output, NumRegs, a per-register sticky storage error.
REQ-018 The block SHALL have err_timeout_o, output, 1, a one-cycle timeout pulse.
REQ-019 The block SHALL have err_cnt_o, output, 8, a saturating count of update and timeout errors.

Function
REQ-020 Each register i SHALL hold three parts: a staged part (~value), a shadow part (~value) and a committed part (value); q_o slice i equals the committed part.
REQ-021 At most one register SHALL be in phase 1 at any time; its index is held internally as the pending index.
REQ-022 A software write in phase 0 SHALL load staged_i <= ~wd_i, set phase_i to 1 and clear the timer.
REQ-023 A software write to the pending register with wd_i == ~staged_i SHALL write committed_i <= wd_i and shadow_i <= staged_i, return phase_i to 0, and pulse qe_o[i]; q_o and qe_o update 1 cycle after we_i.
REQ-024 A software write to the pending register with wd_i != ~staged_i SHALL leave committed_i unchanged, return phase_i to 0, pulse err_update_o[i] 1 cycle later, and increment err_cnt_o.
REQ-025 A phase-0 write to register j while register i is pending SHALL abort i (phase_i -> 0, err_update_o[i] pulse, err_cnt_o +1) and start j in phase 1 in the same cycle.
REQ-026 re_i addressing the pending register SHALL return it to phase 0 with no error; re_i has no effect in any other case.
REQ-027 The timer SHALL increment each cycle a register is pending; on reaching TimeoutCycles (when nonzero) phase returns to 0, err_timeout_o pulses 1 cycle later, and err_cnt_o increments.
REQ-028 de_i[i] SHALL write committed_i <= d_i slice and shadow_i <= ~d_i slice, and pulse qe_o[i] 1 cycle later.
REQ-029 If register i is pending when de_i[i] is asserted, the pending write SHALL be aborted without error.
REQ-030 If de_i[i] and a software write to register i occur in the same cycle, hardware SHALL win, the software write is dropped, and no error is raised.
REQ-031 A storage error on register i SHALL be the condition ~shadow_i != committed_i; err_storage_o[i] is sticky until reset.
REQ-032 While err_storage_o[i] is set, register i SHALL ignore all SW and HW writes, hold q_o, and stay in phase 0.
REQ-033 err_cnt_o SHALL saturate at 255; storage errors SHALL NOT be counted; simultaneous abort and timeout events SHALL count +1 only.

Reset
REQ-034 On rst_i the block SHALL set committed to RESVAL, staged and shadow to ~RESVAL, and phase_o, qe_o, all error outputs, err_cnt_o, the timer and the scrub pointer to 0.
REQ-035 Reset mid-operation SHALL abandon any pending write with no error pulse, effective the cycle after rst_i is sampled.

Configuration
REQ-036 With PRIM_SHADOW_BANK_SCRUB_EN defined, storage checking SHALL use a single comparator stepped by a scrub pointer that advances one register per cycle and wraps from NumRegs-1 to 0; detection latency is at most NumRegs cycles.
REQ-037 Without PRIM_SHADOW_BANK_SCRUB_EN, all registers SHALL be compared every cycle, and err_storage_o[i] SHALL be set 1 cycle after the corruption.

Verification
REQ-038 Scenario: write A5A5A5A5 twice to addr 1 -> qe_o[1] pulses and q_o slice 1 = A5A5A5A5 1 cycle after the second write, with phase_o[1] 1 then 0.
REQ-039 Scenario: write 1 then 2 to addr 0 -> err_update_o[0] pulses, q_o slice 0 = RESVAL, and err_cnt_o = 1.
REQ-040 Scenario: first write to addr 2 then idle 16 cycles -> err_timeout_o pulses, phase_o[2] = 0, err_cnt_o +1; a subsequent write starts phase 1 again.
REQ-041 Scenario: first write to addr 0, then first write to addr 3 -> err_update_o[0] pulses, phase_o = 4'b1000; de_i[3] on the next cycle -> phase_o = 0 and no error.
REQ-042 Scenario: force-flip shadow bit 0 of register 1 -> err_storage_o[1] set within 1 cycle (NumRegs cycles with the scrub macro); later SW and HW writes to register 1 are ignored, and only rst_i clears the error.
REQ-043 Scenario: 300 mismatching write pairs -> err_cnt_o holds 255.
